// File: rtl/adc_fifo_ctrl_if.sv
// rtl/adc_fifo_ctrl_if.sv - push/pop, status and LSRAM bundle for the ADC FIFO controller
//
// Purpose: groups every non-clock/reset signal of adc_fifo_ctrl so the
// controller, the sampling/readout logic and the LSRAM hook up through one port.
//
// Signal summary:
//   flush         user -> ctrl   synchronous clear of FIFO contents
//   wr_en, wdata  user -> ctrl   push request and data
//   rd_en         user -> ctrl   pop request
//   rdata         ctrl -> user   pop data (only meaningful with rd_valid)
//   rd_valid      ctrl -> user   rdata valid this cycle
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                             sticky error flags
//   ram_waddr, ram_wd, ram_wen                      LSRAM write port
//   ram_raddr, ram_ren                              LSRAM read port
//   ram_rd        ram  -> ctrl   LSRAM read data
//
// Modports:
//   slave  - the FIFO controller
//   master - the environment (sampling/readout logic and LSRAM)
interface adc_fifo_ctrl_if #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DWIDTH     = 16
);
  logic                  flush;
  logic                  wr_en;
  logic [DWIDTH-1:0]     wdata;
  logic                  rd_en;
  logic [DWIDTH-1:0]     rdata;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic [DWIDTH-1:0]     ram_wd;
  logic                  ram_wen;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic                  ram_ren;
  logic [DWIDTH-1:0]     ram_rd;

  modport slave (
    input  flush, wr_en, wdata, rd_en, ram_rd,
    output rdata, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow, ram_waddr, ram_wd, ram_wen, ram_raddr, ram_ren
  );

  modport master (
    output flush, wr_en, wdata, rd_en, ram_rd,
    input  rdata, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow, ram_waddr, ram_wd, ram_wen, ram_raddr, ram_ren
  );
endinterface

// File: rtl/adc_fifo_ctrl.sv
// rtl/adc_fifo_ctrl.sv - pointer/flag controller turning a 2-port LSRAM into a synchronous FIFO
//
// Purpose: keeps write/read pointers, occupancy count, full/empty/threshold
// flags and sticky overflow/underflow flags, and drives the LSRAM address and
// enable pins directly from the registered pointers. Read latency is one cycle.
//
// Ports:
//   clk_i    system clock, shared with the LSRAM
//   rst_n_i  asynchronous active-low reset, released synchronously upstream
//   fifo_if  adc_fifo_ctrl_if.slave - push/pop, status and LSRAM signals
module adc_fifo_ctrl #(
  parameter int unsigned DEPTH_LOG2    = 10,
  parameter int unsigned DWIDTH        = 16,
  parameter int unsigned AFULL_THRESH  = 1000,
  parameter int unsigned AEMPTY_THRESH = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  adc_fifo_ctrl_if.slave  fifo_if
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_W  = PW'(2 ** DEPTH_LOG2);
  localparam logic [PW-1:0] AFULL_W  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_W = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] ONE_W    = PW'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_valid_q, rd_valid_d;

  logic          push_ok;
  logic          pop_ok;

  // Acceptance uses this cycle's registered flags, so a push while full is
  // refused even when a pop frees a slot in the same cycle (and vice versa).
  assign push_ok = fifo_if.wr_en & ~full_q  & ~fifo_if.flush;
  assign pop_ok  = fifo_if.rd_en & ~empty_q & ~fifo_if.flush;

  // LSRAM samples these on the same clock edge that advances the pointers.
  assign fifo_if.ram_waddr = wptr_q[DEPTH_LOG2-1:0];
  assign fifo_if.ram_wd    = fifo_if.wdata;
  assign fifo_if.ram_wen   = push_ok;
  assign fifo_if.ram_raddr = rptr_q[DEPTH_LOG2-1:0];
  assign fifo_if.ram_ren   = pop_ok;

  assign fifo_if.rdata        = fifo_if.ram_rd;
  assign fifo_if.rd_valid     = rd_valid_q;
  assign fifo_if.full         = full_q;
  assign fifo_if.empty        = empty_q;
  assign fifo_if.almost_full  = afull_q;
  assign fifo_if.almost_empty = aempty_q;
  assign fifo_if.count        = count_q;
  assign fifo_if.overflow     = ovf_q;
  assign fifo_if.underflow    = unf_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rd_valid_d = pop_ok;

    if (fifo_if.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (push_ok) begin
        wptr_d = wptr_q + ONE_W;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + ONE_W;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + ONE_W;
        2'b01:   count_d = count_q - ONE_W;
        default: count_d = count_q;
      endcase
      if (fifo_if.wr_en && full_q) begin
        ovf_d = 1'b1;
      end
      if (fifo_if.rd_en && empty_q) begin
        unf_d = 1'b1;
      end
    end

    // Flags follow the next count so they line up with the count register.
    full_d   = (count_d == DEPTH_W);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_W);
    aempty_d = (count_d <= AEMPTY_W);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_adc_fifo_ctrl.sv
// tb/tb_adc_fifo_ctrl.sv - self-checking bench for adc_fifo_ctrl with LSRAM model and data scoreboard
module tb_adc_fifo_ctrl;

  localparam int DL    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_fifo_ctrl_if #(.DEPTH_LOG2(DL), .DWIDTH(DW)) bus ();

  adc_fifo_ctrl #(
    .DEPTH_LOG2(DL), .DWIDTH(DW), .AFULL_THRESH(1000), .AEMPTY_THRESH(8)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .fifo_if (bus)
  );

  // LSRAM model: synchronous write, registered read on REN.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_rd_q;
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wd;
    if (bus.ram_ren) ram_rd_q <= mem[bus.ram_raddr];
  end
  assign bus.ram_rd = ram_rd_q;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            m_count = 0;
  int            m_wa = 0;
  int            m_ra = 0;
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            exp_rv = 0;
  bit            m_wr = 0, m_rd = 0, m_flush = 0, m_push = 0, m_pop = 0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] sb[$];
  int            n_valid = 0;

  // Scoreboard monitor: checks RD_VALID timing and popped data order.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (bus.rd_valid !== exp_rv) begin
        fails++;
        $display("FAIL rd_valid: got %0b expected %0b (t=%0t)", bus.rd_valid, exp_rv, $time);
      end
      if (bus.rd_valid) n_valid++;
      if (exp_rv) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rdata: got %h but no data expected", bus.rdata);
        end else begin
          logic [DW-1:0] e;
          e = sb.pop_front();
          if (bus.rdata !== e) begin
            fails++;
            $display("FAIL rdata: got %h expected %h (t=%0t)", bus.rdata, e, $time);
          end
        end
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    m_count = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_unf = 0; exp_rv = 0;
    m_wr = 0; m_rd = 0; m_flush = 0; m_push = 0; m_pop = 0;
  endtask

  // Drive inputs just after a rising edge, return at the falling edge.
  task automatic drive(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit fl);
    bus.wr_en = wr; bus.wdata = wd; bus.rd_en = rd; bus.flush = fl;
    m_wr = wr; m_rd = rd; m_wd = wd; m_flush = fl;
    m_push = wr && (m_count != DEPTH) && !fl;
    m_pop  = rd && (m_count != 0) && !fl;
    @(negedge clk);
  endtask

  // Advance through the rising edge and update the model/scoreboard.
  task automatic tick();
    @(posedge clk);
    if (m_flush) begin
      sb.delete();
      m_count = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (m_wr && m_count == DEPTH) m_ovf = 1;
      if (m_rd && m_count == 0) m_unf = 1;
      if (m_push) begin
        sb.push_back(m_wd);
        m_wa = (m_wa + 1) % DEPTH;
      end
      if (m_pop) m_ra = (m_ra + 1) % DEPTH;
      m_count = m_count + int'(m_push) - int'(m_pop);
    end
    exp_rv = m_pop;
    #1;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, DW'(base + i), 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic do_flush();
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.rd_en = 0; bus.flush = 0; bus.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.rd_valid, bus.overflow, bus.underflow} !== 7'b1100000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 1100000",
               {bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.rd_valid, bus.overflow, bus.underflow});
    end
    tests++;
    if (bus.count !== 11'd0) begin
      fails++;
      $display("FAIL reset_count: got %0d expected 0", bus.count);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int v0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      tests++;
      if (bus.ram_wen !== 1'b1 || bus.ram_waddr !== 10'(i - 1)) begin
        fails++;
        $display("FAIL basic_push: wen=%0b waddr=%0d expected wen=1 waddr=%0d", bus.ram_wen, bus.ram_waddr, i - 1);
      end
      tick();
    end
    tests++;
    if (bus.count !== 11'd5 || bus.empty !== 1'b0) begin
      fails++;
      $display("FAIL basic_count5: count=%0d empty=%0b expected 5/0", bus.count, bus.empty);
    end
    v0 = n_valid;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tests++;
      if (bus.ram_ren !== 1'b1 || bus.ram_raddr !== 10'(i)) begin
        fails++;
        $display("FAIL basic_pop: ren=%0b raddr=%0d expected ren=1 raddr=%0d", bus.ram_ren, bus.ram_raddr, i);
      end
      tick();
    end
    tests++;
    if (bus.count !== 11'd0 || bus.empty !== 1'b1) begin
      fails++;
      $display("FAIL basic_empty: count=%0d empty=%0b expected 0/1", bus.count, bus.empty);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tests++;
    if (n_valid - v0 !== 5) begin
      fails++;
      $display("FAIL basic_valid_cycles: got %0d expected 5", n_valid - v0);
    end
    tick();
  endtask

  task automatic test_fill();
    do_flush();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(16'h4000 + i), 1'b0, 1'b0);
      tick();
      if (i == 998) begin
        tests++;
        if (bus.almost_full !== 1'b0) begin
          fails++;
          $display("FAIL afull_999: got %0b expected 0", bus.almost_full);
        end
      end
      if (i == 999) begin
        tests++;
        if (bus.almost_full !== 1'b1 || bus.count !== 11'd1000) begin
          fails++;
          $display("FAIL afull_1000: afull=%0b count=%0d expected 1/1000", bus.almost_full, bus.count);
        end
      end
    end
    tests++;
    if (bus.full !== 1'b1 || bus.count !== 11'd1024) begin
      fails++;
      $display("FAIL full: full=%0b count=%0d expected 1/1024", bus.full, bus.count);
    end
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
    tests++;
    if (bus.ram_wen !== 1'b0) begin
      fails++;
      $display("FAIL push_when_full_wen: got %0b expected 0", bus.ram_wen);
    end
    tick();
    tests++;
    if (bus.overflow !== 1'b1 || bus.count !== 11'd1024) begin
      fails++;
      $display("FAIL overflow: ovf=%0b count=%0d expected 1/1024", bus.overflow, bus.count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      if (m_count == 9 || m_count == 8) begin
        tests++;
        if (bus.almost_empty !== (m_count == 8)) begin
          fails++;
          $display("FAIL aempty_at_%0d: got %0b expected %0b", m_count, bus.almost_empty, m_count == 8);
        end
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tests++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      fails++;
      $display("FAIL fill_drained: empty=%0b ovf=%0b expected 1/1", bus.empty, bus.overflow);
    end
  endtask

  task automatic test_wrap();
    int pushes = 0;
    int cyc = 0;
    int wdat = 16'h8000;
    bit wr, rd;
    do_flush();
    fill(500, 16'h7000);
    while (pushes < 1500 && cyc < 20000) begin
      wr = ($urandom_range(0, 1) == 1) && (m_count < 900);
      rd = ($urandom_range(0, 1) == 1) && (m_count > 100);
      drive(wr, DW'(wdat), rd, 1'b0);
      if (wr) begin
        tests++;
        if (bus.ram_waddr !== 10'(m_wa)) begin
          fails++;
          $display("FAIL wrap_waddr: got %0d expected %0d", bus.ram_waddr, m_wa);
        end
      end
      if (rd) begin
        tests++;
        if (bus.ram_raddr !== 10'(m_ra)) begin
          fails++;
          $display("FAIL wrap_raddr: got %0d expected %0d", bus.ram_raddr, m_ra);
        end
      end
      tick();
      tests++;
      if (bus.count !== 11'(m_count)) begin
        fails++;
        $display("FAIL wrap_count: got %0d expected %0d", bus.count, m_count);
      end
      if (wr) begin
        pushes++;
        wdat++;
      end
      cyc++;
    end
    tests++;
    if (pushes < 1500) begin
      fails++;
      $display("FAIL wrap_budget: got %0d pushes expected 1500", pushes);
    end
    drain(m_count);
  endtask

  task automatic test_simultaneous();
    do_flush();
    fill(DEPTH, 16'hC000);
    drive(1'b1, 16'hAAAA, 1'b1, 1'b0);
    tests++;
    if (bus.ram_wen !== 1'b0 || bus.ram_ren !== 1'b1) begin
      fails++;
      $display("FAIL sim_full_en: wen=%0b ren=%0b expected 0/1", bus.ram_wen, bus.ram_ren);
    end
    tick();
    tests++;
    if (bus.count !== 11'd1023 || bus.overflow !== 1'b1) begin
      fails++;
      $display("FAIL sim_full: count=%0d ovf=%0b expected 1023/1", bus.count, bus.overflow);
    end
    drain(1023);
    drive(1'b1, 16'h5555, 1'b1, 1'b0);
    tests++;
    if (bus.ram_wen !== 1'b1 || bus.ram_ren !== 1'b0) begin
      fails++;
      $display("FAIL sim_empty_en: wen=%0b ren=%0b expected 1/0", bus.ram_wen, bus.ram_ren);
    end
    tick();
    tests++;
    if (bus.count !== 11'd1 || bus.underflow !== 1'b1) begin
      fails++;
      $display("FAIL sim_empty: count=%0d unf=%0b expected 1/1", bus.count, bus.underflow);
    end
    fill(499, 16'h3000);
    drive(1'b1, 16'h6666, 1'b1, 1'b0);
    tick();
    tests++;
    if (bus.count !== 11'd500) begin
      fails++;
      $display("FAIL sim_mid_count: got %0d expected 500", bus.count);
    end
    drain(500);
  endtask

  task automatic test_flush();
    do_flush();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    fill(300, 16'h1100);
    tests++;
    if (bus.count !== 11'd300 || bus.underflow !== 1'b1) begin
      fails++;
      $display("FAIL flush_pre: count=%0d unf=%0b expected 300/1", bus.count, bus.underflow);
    end
    drive(1'b1, 16'h7777, 1'b1, 1'b1);
    tests++;
    if (bus.ram_wen !== 1'b0 || bus.ram_ren !== 1'b0) begin
      fails++;
      $display("FAIL flush_en: wen=%0b ren=%0b expected 0/0", bus.ram_wen, bus.ram_ren);
    end
    tick();
    tests++;
    if ({bus.empty, bus.overflow, bus.underflow, bus.rd_valid} !== 4'b1000 || bus.count !== 11'd0) begin
      fails++;
      $display("FAIL flush_post: empty/ovf/unf/rv=%b count=%0d expected 1000/0",
               {bus.empty, bus.overflow, bus.underflow, bus.rd_valid}, bus.count);
    end
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
    tests++;
    if (bus.ram_waddr !== 10'd0) begin
      fails++;
      $display("FAIL flush_waddr: got %0d expected 0", bus.ram_waddr);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (bus.ram_raddr !== 10'd0 || bus.ram_ren !== 1'b1) begin
      fails++;
      $display("FAIL flush_raddr: raddr=%0d ren=%0b expected 0/1", bus.ram_raddr, bus.ram_ren);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    fill(3, 16'h00A0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    tests++;
    if (bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre_valid: got %0b expected 1", bus.rd_valid);
    end
    bus.wr_en = 0; bus.rd_en = 0; bus.flush = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async_valid: got %0b expected 0", bus.rd_valid);
    end
    tests++;
    if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.overflow, bus.underflow} !== 6'b110000
        || bus.count !== 11'd0) begin
      fails++;
      $display("FAIL rst_mid_state: flags=%b count=%0d expected 110000/0",
               {bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.overflow, bus.underflow}, bus.count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    tests++;
    if (bus.ram_waddr !== 10'd0 || bus.ram_wen !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_resume: waddr=%0d wen=%0b expected 0/1", bus.ram_waddr, bus.ram_wen);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tests++;
    if (bus.count !== 11'd0 || bus.empty !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_end: count=%0d empty=%0b expected 0/1", bus.count, bus.empty);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_fifo_ctrl.md
Name: adc_fifo_ctrl

Overview:
- Pointer and flag controller that turns the 1024x16 two-port LSRAM in the ADC FIFO into a synchronous FIFO.
- The ADC sampling logic pushes 16-bit samples; the readout/transmit logic pops them.
- The block drives the RAM's write and read address/enable pins and returns read data with a valid strobe.
- It also maintains the occupancy count, full/empty/threshold flags, and sticky error flags.

Parameters:
DEPTH_LOG2, 10, address width; FIFO depth = 2**DEPTH_LOG2 = 1024 words
DWIDTH, 16, data width
AFULL_THRESH, 1000, ALMOST_FULL asserts when COUNT >= this value
AEMPTY_THRESH, 8, ALMOST_EMPTY asserts when COUNT <= this value

Ports:
CLK  in  1  single system clock; shared with the LSRAM
RESET_N  in  1  asynchronous active-low reset
FLUSH  in  1  synchronous clear of the FIFO contents
WR_EN  in  1  push request
WDATA  in  DWIDTH  push data
RD_EN  in  1  pop request
RDATA  out  DWIDTH  pop data; equals RAM_RD
RD_VALID  out  1  RDATA valid in this cycle
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
ALMOST_FULL  out  1  COUNT >= AFULL_THRESH
ALMOST_EMPTY  out  1  COUNT <= AEMPTY_THRESH
COUNT  out  DEPTH_LOG2+1  current occupancy, 0..1024
OVERFLOW  out  1  sticky: push attempted while FULL
UNDERFLOW  out  1  sticky: pop attempted while EMPTY
RAM_WADDR  out  DEPTH_LOG2  to LSRAM WADDR
RAM_WD  out  DWIDTH  to LSRAM WD
RAM_WEN  out  1  to LSRAM WEN (active high)
RAM_RADDR  out  DEPTH_LOG2  to LSRAM RADDR
RAM_REN  out  1  to LSRAM REN (active high)
RAM_RD  in  DWIDTH  from LSRAM RD

Behaviour:
- Reset: all registers clear asynchronously on RESET_N low; release is synchronous to CLK.
  - Pointer and count registers go to 0.
  - EMPTY=1, ALMOST_EMPTY=1; FULL, ALMOST_FULL, RD_VALID, OVERFLOW, UNDERFLOW = 0; COUNT=0.
- Pointers: wptr and rptr are each DEPTH_LOG2+1 bits. The MSB is the wrap bit.
  - COUNT = wptr - rptr, computed modulo 2**(DEPTH_LOG2+1) and held in a register.
  - Address 1023 wraps to 0.
- Accept rules use the registered flags from the current cycle:
  - push_ok = WR_EN & ~FULL & ~FLUSH
  - pop_ok = RD_EN & ~EMPTY & ~FLUSH
- RAM drive is combinational from the registered pointers.
  - RAM_WADDR = wptr[DEPTH_LOG2-1:0], RAM_WD = WDATA, RAM_WEN = push_ok.
  - RAM_RADDR = rptr[DEPTH_LOG2-1:0], RAM_REN = pop_ok.
  - The LSRAM captures these on the same CLK edge.
- Read latency is 1 cycle.
  - RD_VALID is the registered pop_ok: high exactly in the cycle after an accepted pop.
  - RDATA = RAM_RD. RDATA is undefined when RD_VALID=0; verification must not check it then.
- Pointer and count update per cycle:
  - push_ok: wptr+1.
  - pop_ok: rptr+1.
  - Both: COUNT unchanged.
  - Push only: COUNT+1. Pop only: COUNT-1.
- Flags are registered and derived from the next COUNT, so they are valid in the same cycle as COUNT.
- Full and simultaneous pop: a push while FULL is rejected even if a pop is accepted in the same cycle. OVERFLOW sets.
- Empty and simultaneous push: a pop while EMPTY is rejected even if a push is accepted in the same cycle. UNDERFLOW sets.
- Read-during-write to the same address never occurs, because a read requires COUNT >= 1.
- FLUSH:
  - Takes priority over WR_EN and RD_EN; no RAM enable is asserted in that cycle.
  - Next cycle: wptr=rptr=0, COUNT=0, EMPTY=1, OVERFLOW=0, UNDERFLOW=0, RD_VALID=0.
  - RAM contents are not cleared.
- Reset asserted mid-transfer drops RD_VALID immediately. Data in flight is discarded.
- The block has no other state machine.

Test Plan:
- Reset then 5 pushes (0x0001..0x0005), then 5 pops on consecutive cycles:
  - RD_VALID is high for 5 cycles starting 1 cycle after the first RD_EN.
  - RDATA is 0x0001..0x0005 in order.
  - COUNT goes 0->5->0; EMPTY rises on the cycle after the last pop.
- 1024 pushes of ascending data:
  - FULL=1 and COUNT=1024.
  - ALMOST_FULL asserts at the 1000th push.
  - A 1025th push is rejected (RAM_WEN=0) and OVERFLOW=1.
  - Popping all 1024 words returns the data intact.
- Wrap-around: push/pop 1500 words while keeping COUNT between 100 and 900:
  - Addresses wrap 1023->0.
  - Data order is preserved.
  - COUNT is never wrong.
- Simultaneous events:
  - At COUNT=1024 with WR_EN=RD_EN=1: pop accepted, push rejected, COUNT=1023, OVERFLOW=1.
  - At COUNT=0 with both asserted: push accepted, no RD_VALID, COUNT=1, UNDERFLOW=1.
  - At COUNT=500 with both asserted: COUNT stays 500.
- FLUSH at COUNT=300 with WR_EN=RD_EN=1 in the same cycle:
  - No RAM enables in that cycle.
  - Next cycle: COUNT=0, EMPTY=1, sticky flags cleared.
  - The next push/pop pair returns the new data.
- RESET_N pulsed low in the cycle after a pop:
  - RD_VALID drops asynchronously.
  - All outputs take their reset values while RESET_N is low.
  - Normal operation resumes after release.
